// File: rtl/scaler_ctrl.sv
// scaler_ctrl: run controller for the rom_to_ram scaling datapath.
//   Clears the frame RAM, holds the engine in reset for an arm interval,
//   then forwards the engine RAM port until done or watchdog expiry.
// Latency: start -> first clear write 1 cycle; RUN RAM port is combinational.
// Backpressure: none; start/mode_in are ignored while busy.
// Ports: clk/reset_n; start, mode_in (board controls); seletor, eng_reset,
//   eng_done, eng_wraddr/eng_data/eng_wren (datapath side); ram_wraddr,
//   ram_data, ram_wren (frame RAM); busy, done, done_pulse, error,
//   err_code, frame_cnt (status).
module scaler_ctrl #(
  parameter int          RAM_DEPTH  = 76800,
  parameter int          ADDR_W     = 19,
  parameter logic [7:0]  CLEAR_VAL  = 8'h00,
  parameter int          ARM_CYCLES = 2,
  parameter int          TIMEOUT    = 200000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode_in,
  output logic [1:0]        seletor,
  output logic              eng_reset,
  input  logic              eng_done,
  input  logic [ADDR_W-1:0] eng_wraddr,
  input  logic [7:0]        eng_data,
  input  logic              eng_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              done_pulse,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [7:0]        frame_cnt
);

  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ARM_W-1:0]  LAST_ARM  = ARM_W'(ARM_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT);

  logic [2:0]        state_q, state_d;
  logic [1:0]        seletor_q, seletor_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ARM_W-1:0]  arm_q, arm_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              done_q, done_d;
  logic              done_pulse_q, done_pulse_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    seletor_d    = seletor_q;
    addr_d       = addr_q;
    arm_d        = arm_q;
    wdog_d       = wdog_q;
    done_d       = done_q;
    done_pulse_d = 1'b0;
    error_d      = error_q;
    err_code_d   = err_code_q;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          if (mode_in[1]) begin
            // Unsupported algorithm: reject without touching seletor or RAM.
            state_d    = S_ERR;
            done_d     = 1'b0;
            error_d    = 1'b1;
            err_code_d = 2'b01;
          end else begin
            state_d    = S_CLEAR;
            seletor_d  = mode_in;
            done_d     = 1'b0;
            error_d    = 1'b0;
            err_code_d = 2'b00;
            addr_d     = '0;
          end
        end
      end
      S_CLEAR: begin
        // Counter holds at the last address so it never leaves the RAM range.
        if (addr_q == LAST_ADDR) begin
          state_d = S_ARM;
          arm_d   = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_ARM: begin
        if (arm_q == LAST_ARM) begin
          state_d = S_RUN;
          wdog_d  = '0;
        end else begin
          arm_d = arm_q + 1'b1;
        end
      end
      S_RUN: begin
        // Engine completion wins over a simultaneous watchdog expiry.
        if (eng_done) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          done_pulse_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
        end else if (wdog_q == WD_LIMIT) begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = 2'b10;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_CLEAR) || (state_d == S_ARM) || (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      seletor_q    <= 2'b00;
      addr_q       <= '0;
      arm_q        <= '0;
      wdog_q       <= '0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 2'b00;
      frame_cnt_q  <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seletor_q    <= seletor_d;
      addr_q       <= addr_d;
      arm_q        <= arm_d;
      wdog_q       <= wdog_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      frame_cnt_q  <= frame_cnt_d;
      busy_q       <= busy_d;
    end
  end

  // The engine runs only in RUN and DONE; in DONE it keeps its done output.
  assign eng_reset = !((state_q == S_RUN) || (state_q == S_DONE));

  // CLEAR drives straight from flops; RUN is a zero-latency pass-through.
  always_comb begin
    ram_wraddr = '0;
    ram_data   = 8'h00;
    ram_wren   = 1'b0;
    if (state_q == S_CLEAR) begin
      ram_wraddr = addr_q;
      ram_data   = CLEAR_VAL;
      ram_wren   = 1'b1;
    end else if (state_q == S_RUN) begin
      ram_wraddr = eng_wraddr;
      ram_data   = eng_data;
      ram_wren   = eng_wren;
    end
  end

  assign seletor    = seletor_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign done_pulse = done_pulse_q;
  assign error      = error_q;
  assign err_code   = err_code_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/scaler_ctrl.md
# scaler_ctrl

Run controller for the `rom_to_ram` scaling datapath.
- On a start request it latches the algorithm select, clears the 320x240 frame RAM to a background value, and holds the scaler engine in reset for a fixed arm interval.
- It then releases the engine and forwards its RAM write port until the engine reports done, or until a watchdog expires.
- It sits between the board controls (keys and switches, already debounced) and the `rom_to_ram` instance, and owns the frame RAM write port.

## Interface
Parameters:
- RAM_DEPTH, 76800 — frame RAM words to clear (320*240).
- ADDR_W, 19 — RAM address width.
- CLEAR_VAL, 8'h00 — background pixel value written during clear.
- ARM_CYCLES, 2 — cycles the engine reset is held after clear (minimum 1).
- TIMEOUT, 200000 — maximum RUN cycles before error. Counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle start request.
- mode_in  in  2  requested algorithm (00 replication, 01 decimation, 10/11 unsupported).
- seletor  out  2  latched mode to the datapath.
- eng_reset  out  1  active-high reset to the datapath.
- eng_done  in  1  datapath done.
- eng_wraddr  in  ADDR_W  datapath RAM address.
- eng_data  in  8  datapath RAM data.
- eng_wren  in  1  datapath RAM write enable.
- ram_wraddr  out  ADDR_W  frame RAM address.
- ram_data  out  8  frame RAM data.
- ram_wren  out  1  frame RAM write enable.
- busy  out  1  run in progress (CLEAR, ARM or RUN).
- done  out  1  level; the last run completed.
- done_pulse  out  1  one cycle on entry to DONE.
- error  out  1  level; the last run failed.
- err_code  out  2  01 unsupported mode, 10 timeout, 00 none.
- frame_cnt  out  8  completed runs; wraps 255→0.

## Operation
States: IDLE, CLEAR, ARM, RUN, DONE, ERR.

- **IDLE / DONE / ERR**: the FSM samples `start`.
  - If mode_in is 10 or 11: go to ERR, set err_code=01, leave seletor unchanged.
  - Otherwise: latch seletor=mode_in, clear done, error and err_code, reset the address counter to 0, and go to CLEAR.
- **CLEAR**: each cycle drives ram_wren=1, ram_data=CLEAR_VAL, ram_wraddr=counter, then increments the counter. After the write at address RAM_DEPTH-1, go to ARM.
- **ARM**: eng_reset=1 and ram_wren=0 for ARM_CYCLES cycles, then go to RUN. The watchdog clears on ARM exit.
- **RUN**: eng_reset=0. ram_wraddr, ram_data and ram_wren equal eng_wraddr, eng_data and eng_wren combinationally. The watchdog increments every cycle.
  - eng_done=1 → DONE, frame_cnt+1.
  - Otherwise, if the watchdog reaches TIMEOUT → ERR with err_code=10.
  - eng_done takes priority when both happen in the same cycle.
- **DONE**: eng_reset=0, so the engine holds its done output. ram_wren=0.
- **ERR**: eng_reset=1 and ram_wren=0.
- **IDLE**: eng_reset=1 and ram_wren=0.

Rules:
- `start` and `mode_in` are ignored while busy=1. A mode change has no effect mid-run.
- The address counter is ADDR_W bits and never exceeds RAM_DEPTH-1.
- reset_n low at any time, including mid-CLEAR or mid-RUN, forces the reset values below immediately. The partially cleared RAM is not restored.
- Reset values:
  - state IDLE, seletor 00, eng_reset 1;
  - ram_wraddr 0, ram_data 0, ram_wren 0;
  - busy 0, done 0, done_pulse 0, error 0, err_code 00, frame_cnt 0;
  - watchdog and address counter 0.

## Timing
- `start` sampled high at edge t → state CLEAR after t. The first clear write (address 0) appears in cycle t+1.
- CLEAR lasts exactly RAM_DEPTH cycles. ARM lasts ARM_CYCLES cycles.
- The first RUN cycle is t+1+RAM_DEPTH+ARM_CYCLES.
- eng_done high at edge e → done=1 and done_pulse=1 after e. done_pulse falls after e+1.
- Timeout: ERR is entered on the edge where the watchdog equals TIMEOUT, i.e. after TIMEOUT+1 RUN cycles without eng_done.
- An unsupported mode reaches ERR one edge after start. busy never asserts in that case.
- busy is a registered decode of the state.
- In RUN, the RAM port adds no latency (combinational pass-through). In CLEAR, the RAM port outputs are registered.

## Test plan
Bench parameters: RAM_DEPTH=16, ARM_CYCLES=2, TIMEOUT=40; engine model asserts eng_done 20 cycles after eng_reset falls.

- **Reset**: reset_n=0 → all outputs at reset values, eng_reset=1. Release, then start=1, mode_in=01 → seletor=01; 16 writes of 8'h00 at addresses 0..15 on consecutive cycles; eng_reset high for 2 cycles, then low; done_pulse once; frame_cnt=1.
- **Unsupported mode**: start with mode_in=11 → error=1, err_code=01 one cycle later; busy stays 0; no RAM write; seletor unchanged.
- **Timeout**: engine model never asserts done → ERR after 41 RUN cycles, err_code=10, eng_reset=1, ram_wren=0. A following valid start clears error and reruns.
- **Ignored inputs while busy**: pulse start and toggle mode_in to 00 during CLEAR and during RUN → no restart, seletor stays 01, run length unchanged.
- **Reset mid-run**: reset_n=0 during CLEAR at address 7 → ram_wren=0 immediately, state IDLE, frame_cnt=0.
- **Counter wrap and priority**: 256 back-to-back runs → frame_cnt wraps to 0. eng_done coincident with watchdog=TIMEOUT → DONE, not ERR.
